// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN engine: reads N sprite rows from program RAM and XORs them into the 64x32 framebuffer.
// Define SPRITE_WRAP_EN to wrap sprites around the screen edges instead of clipping them.
`timescale 1ns/1ps
module chip8_sprite_draw #(
    parameter int FB_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [3:0]  n,
    input  logic [11:0] i_addr,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  fb_addr,
    input  logic [7:0]  fb_rdata,
    output logic [7:0]  fb_wdata,
    output logic        fb_we,
    output logic        busy,
    output logic        done,
    output logic        collision
);

    generate
        if (FB_RD_LAT != 1) begin : g_fb_lat_check
            $error("chip8_sprite_draw: only FB_RD_LAT=1 is supported");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        SPR_ADDR,
        SPR_DATA,
        WR_L,
        RD_R,
        WR_R,
        DONE
    } state_t;

    function automatic logic [7:0] fb_byte_addr(input logic [4:0] r, input logic [2:0] c);
        return {r, c};
    endfunction

    function automatic logic [15:0] align_sprite(input logic [7:0] s, input logic [2:0] shift);
        return {s, 8'h00} >> shift;
    endfunction

    function automatic logic pixel_hit(input logic [7:0] old_byte, input logic [7:0] spr_byte);
        return |(old_byte & spr_byte);
    endfunction

    state_t      state, state_nx;
    logic [4:0]  row;
    logic [4:0]  row_nx;
    logic        coll_r;
    logic        accept;
    logic        row_adv;
    logic        last_row;
    logic        right_on;

    logic [5:0]  x0;
    logic [4:0]  y0;
    logic [11:0] base;
    logic [3:0]  rows;
    logic [7:0]  spr;

    logic [15:0] sh;
    logic [4:0]  row_y;
    logic [2:0]  col_l;
    logic [2:0]  col_r;

    logic        unused_bits;
    assign unused_bits = &{1'b0, x[7:6], y[7:5]};

    assign sh     = align_sprite(spr, x0[2:0]);
    assign row_y  = y0 + row;
    assign col_l  = x0[5:3];
    assign col_r  = x0[5:3] + 3'd1;
    assign row_nx = row + 5'd1;

    // Row-end decision is folded into the last write state, so it costs no cycle.
`ifdef SPRITE_WRAP_EN
    assign last_row = (row_nx == {1'b0, rows});
    assign right_on = (x0[2:0] != 3'd0);
`else
    assign last_row = (row_nx == {1'b0, rows}) || (({1'b0, y0} + {1'b0, row_nx}) >= 6'd32);
    assign right_on = (x0[2:0] != 3'd0) && (x0[5:3] != 3'd7);
`endif

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        row_adv  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (n == 4'd0) ? DONE : SPR_ADDR;
                end else begin
                    state_nx = IDLE;
                end
            end
            SPR_ADDR: state_nx = SPR_DATA;
            SPR_DATA: state_nx = WR_L;
            WR_L: begin
                if (right_on) begin
                    state_nx = RD_R;
                end else begin
                    row_adv  = 1'b1;
                    state_nx = last_row ? DONE : SPR_ADDR;
                end
            end
            RD_R: state_nx = WR_R;
            WR_R: begin
                row_adv  = 1'b1;
                state_nx = last_row ? DONE : SPR_ADDR;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_addr = 12'd0;
        fb_addr  = 8'd0;
        fb_wdata = 8'd0;
        fb_we    = 1'b0;
        case (state)
            SPR_ADDR: mem_addr = base + {7'd0, row};
            SPR_DATA: fb_addr  = fb_byte_addr(row_y, col_l);
            WR_L: begin
                fb_addr  = fb_byte_addr(row_y, col_l);
                fb_wdata = fb_rdata ^ sh[15:8];
                fb_we    = 1'b1;
            end
            RD_R: fb_addr = fb_byte_addr(row_y, col_r);
            WR_R: begin
                fb_addr  = fb_byte_addr(row_y, col_r);
                fb_wdata = fb_rdata ^ sh[7:0];
                fb_we    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign collision = coll_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            row    <= 5'd0;
            coll_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                row    <= 5'd0;
                coll_r <= 1'b0;
            end else begin
                if (row_adv) begin
                    row <= row_nx;
                end
                if (state == WR_L) begin
                    coll_r <= coll_r | pixel_hit(fb_rdata, sh[15:8]);
                end else if (state == WR_R) begin
                    coll_r <= coll_r | pixel_hit(fb_rdata, sh[7:0]);
                end
            end
        end
    end

    // Draw parameters and the fetched sprite row; only meaningful while busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            x0   <= x[5:0];
            y0   <= y[4:0];
            base <= i_addr;
            rows <= n;
        end
        if (state == SPR_DATA) begin
            spr <= mem_dout;
        end
    end

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Scoreboard bench for chip8_sprite_draw: a pixel-level framebuffer model predicts every fb write and done.
`timescale 1ns/1ps
module tb_chip8_sprite_draw;

`ifdef SPRITE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  x = 8'd0;
    logic [7:0]  y = 8'd0;
    logic [3:0]  n = 4'd0;
    logic [11:0] i_addr = 12'd0;
    logic [11:0] mem_addr;
    logic [7:0]  mem_dout = 8'd0;
    logic [7:0]  fb_addr;
    logic [7:0]  fb_rdata = 8'd0;
    logic [7:0]  fb_wdata;
    logic        fb_we;
    logic        busy;
    logic        done;
    logic        collision;

    chip8_sprite_draw #(.FB_RD_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .x(x), .y(y), .n(n), .i_addr(i_addr),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
        .fb_wdata(fb_wdata), .fb_we(fb_we), .busy(busy), .done(done), .collision(collision)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:4095];
    logic [7:0] fb_mem [0:255];
    int cyc = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mem_dout <= ram[mem_addr];
        fb_rdata <= fb_mem[fb_addr];
        if (fb_we) fb_mem[fb_addr] <= fb_wdata;
    end

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int coll; int cyc; int start; } dn_t;
    wr_t wq[$];
    dn_t dq[$];
    bit  pix [0:31][0:63];
    int  n_cmp = 0;
    int  n_fail = 0;
    int  last_lat = -1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int r, input int c);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[7-k] = pix[r][c*8+k];
        return b;
    endfunction

    // Toggle sprite pixels on the model screen and predict the byte writes and done timing.
    task automatic model_draw(input logic [7:0] xx, input logic [7:0] yy, input logic [3:0] nn,
                              input logic [11:0] aa, input bit with_done);
        int x0, y0, lat, c, py, px;
        bit coll, right;
        logic [7:0] s;
        wr_t w;
        dn_t d;
        x0 = int'(xx) % 64;
        y0 = int'(yy) % 32;
        c = x0 / 8;
        lat = 1;
        coll = 1'b0;
        right = (x0 % 8 != 0) && (WRAP || c < 7);
        for (int r = 0; r < int'(nn); r++) begin
            py = y0 + r;
            if (py >= 32) begin
                if (WRAP) py -= 32;
                else break;
            end
            s = ram[(int'(aa) + r) % 4096];
            for (int k = 0; k < 8; k++) begin
                if (s[7-k]) begin
                    px = x0 + k;
                    if (px >= 64) begin
                        if (WRAP) px -= 64;
                        else continue;
                    end
                    coll |= pix[py][px];
                    pix[py][px] = ~pix[py][px];
                end
            end
            w.addr = py * 8 + c;
            w.data = int'(ref_byte(py, c));
            wq.push_back(w);
            if (right) begin
                w.addr = py * 8 + (c + 1) % 8;
                w.data = int'(ref_byte(py, (c + 1) % 8));
                wq.push_back(w);
            end
            lat += right ? 5 : 3;
        end
        if (with_done) begin
            d.coll = int'(coll);
            d.cyc = cyc + lat;
            d.start = cyc;
            dq.push_back(d);
        end
    endtask

    wr_t mon_w;
    dn_t mon_d;
    always @(negedge clk) begin
        if (reset_n) begin
            if (fb_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
                end else begin
                    mon_w = wq.pop_front();
                    check("wr_addr", 32'(fb_addr), mon_w.addr);
                    check("wr_data", 32'(fb_wdata), mon_w.data);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_d = dq.pop_front();
                    check("done_coll", 32'(collision), mon_d.coll);
                    check("done_cycle", cyc, mon_d.cyc);
                    last_lat = cyc - mon_d.start;
                end
            end
        end
    end

    task automatic draw(input logic [7:0] xx, input logic [7:0] yy, input logic [3:0] nn,
                        input logic [11:0] aa, input bit poke);
        int k;
        @(negedge clk);
        model_draw(xx, yy, nn, aa, 1'b1);
        start = 1'b1; x = xx; y = yy; n = nn; i_addr = aa;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (dq.size() != 0 && k < 400) begin
            if (poke) begin
                x = 8'($urandom); y = 8'($urandom); n = 4'($urandom); i_addr = 12'($urandom);
                start = (k == 2) && busy;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (dq.size() != 0) begin
            check("draw_timeout", dq.size(), 0);
            wq.delete();
            dq.delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) fb_mem[i] = 8'h00;
        ram[0] = 8'hF0; ram[1] = 8'h90; ram[2] = 8'h90; ram[3] = 8'h90; ram[4] = 8'hF0;
        for (int i = 0; i < 5; i++) ram[12'h100 + i] = 8'hF0;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_coll", collision, 0);
        check("rst_we", fb_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_wdata", fb_wdata, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        draw(8'd0, 8'd0, 4'd5, 12'h000, 1'b0);
        check("font_b0", fb_mem[8'h00], 8'hF0);
        check("font_b1", fb_mem[8'h08], 8'h90);
        check("font_b2", fb_mem[8'h10], 8'h90);
        check("font_b3", fb_mem[8'h18], 8'h90);
        check("font_b4", fb_mem[8'h20], 8'hF0);
        check("font_lat", last_lat, 16);
        check("font_coll", collision, 0);

        draw(8'd0, 8'd0, 4'd5, 12'h000, 1'b0);
        check("redraw_coll", collision, 1);
        check("redraw_b0", fb_mem[8'h00], 8'h00);
        check("redraw_b4", fb_mem[8'h20], 8'h00);

        draw(8'd3, 8'd0, 4'd1, 12'h100, 1'b0);
        check("unal_left", fb_mem[8'h00], 8'h1E);
        check("unal_right", fb_mem[8'h01], 8'h00);
        check("unal_lat", last_lat, 6);

        draw(8'd60, 8'd30, 4'd5, 12'h100, 1'b0);
        check("clip_r30", fb_mem[8'hF7], 8'h0F);
        check("clip_r31", fb_mem[8'hFF], 8'h0F);
        check("clip_lat", last_lat, WRAP ? 26 : 7);

        draw(8'd0, 8'd0, 4'd0, 12'h000, 1'b0);
        check("n0_lat", last_lat, 1);
        check("n0_coll", collision, 0);

        draw(8'd70, 8'd2, 4'd3, 12'h000, 1'b0);
        check("x70_left", fb_mem[8'h10], 8'h03);
        check("x70_right", fb_mem[8'h11], 8'hC0);
        check("x70_lat", last_lat, 16);

        // Abort a draw by reset while row 2 is being written.
        @(negedge clk);
        model_draw(8'd8, 8'd4, 4'd2, 12'h000, 1'b0);
        start = 1'b1; x = 8'd8; y = 8'd4; n = 4'd5; i_addr = 12'h000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 check("rst_in_wrl", fb_we, 1);
        reset_n = 1'b0;
        #1;
        check("abort_we", fb_we, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_wq", wq.size(), 0);
        check("abort_coll", collision, 0);
        repeat (5) @(negedge clk);
        draw(8'd8, 8'd4, 4'd5, 12'h000, 1'b0);
        check("after_abort_coll", collision, 1);

        for (int t = 0; t < 40; t++) begin
            draw(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 12'($urandom), t[0]);
        end

        repeat (3) @(negedge clk);
        check("end_wq_empty", wq.size(), 0);
        check("end_dq_empty", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
